// File: rtl/cpu_clock_ctrl_if.sv
// -----------------------------------------------------------------------------
// cpu_clock_ctrl_if
// Groups the control inputs and status outputs of cpu_clock_ctrl.
//   mode      : 00 STOP, 01 RUN, 10 STEP, 11 BURST (synchronous to the clock)
//   step_btn  : raw asynchronous push-button, active-high
//   burst_len : pulses per burst, sampled when a burst starts
//   halt      : CPU halt status, active-high
//   clk_en    : one-cycle CPU clock-enable pulse
//   clk_cyc   : heartbeat square wave, period 2*Div clock cycles
//   busy      : high while a burst is in progress
//   halted    : registered copy of halt
// The master drives the controls; the slave is the clock controller.
// -----------------------------------------------------------------------------
interface cpu_clock_ctrl_if #(
    parameter int unsigned BurstWidth = 8
);
    logic [1:0]            mode;
    logic                  step_btn;
    logic [BurstWidth-1:0] burst_len;
    logic                  halt;
    logic                  clk_en;
    logic                  clk_cyc;
    logic                  busy;
    logic                  halted;

    modport master (
        output mode, step_btn, burst_len, halt,
        input  clk_en, clk_cyc, busy, halted
    );

    modport slave (
        input  mode, step_btn, burst_len, halt,
        output clk_en, clk_cyc, busy, halted
    );
endinterface

// File: rtl/cpu_clock_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_clock_ctrl
// Generates a one-cycle CPU clock-enable from the board clock in one of four
// modes (stop, free-run, debounced single-step, N-pulse burst), plus a 50%
// heartbeat. A registered Halt blocks every enable pulse.
// Ports:
//   clk_i  : board clock, all logic on the rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : cpu_clock_ctrl_if.slave (mode/step_btn/burst_len/halt in,
//            clk_en/clk_cyc/busy/halted out, all outputs registered)
// -----------------------------------------------------------------------------
module cpu_clock_ctrl #(
    parameter int unsigned ClkFreqHz      = 16000000,
    parameter int unsigned RunFreqHz      = 1,
    parameter int unsigned CntWidth       = 24,
    parameter int unsigned DebounceCycles = 16000,
    parameter int unsigned DebWidth       = 16,
    parameter int unsigned BurstWidth     = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    cpu_clock_ctrl_if.slave   bus
);

    localparam int unsigned Div = ClkFreqHz / (2 * RunFreqHz);
    localparam logic [CntWidth-1:0] DivLast = CntWidth'(Div - 32'd1);
    localparam logic [DebWidth-1:0] DebLast = DebWidth'(DebounceCycles - 32'd1);

    localparam logic [1:0] ModeStop  = 2'b00;
    localparam logic [1:0] ModeRun   = 2'b01;
    localparam logic [1:0] ModeStep  = 2'b10;
    localparam logic [1:0] ModeBurst = 2'b11;

    if (Div == 0) begin : g_div_check
        $error("cpu_clock_ctrl: ClkFreqHz/(2*RunFreqHz) must be >= 1");
    end
    if (DebounceCycles == 0) begin : g_deb_check
        $error("cpu_clock_ctrl: DebounceCycles must be >= 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RUN        = 3'd1,
        ST_STEP       = 3'd2,
        ST_BURST_WAIT = 3'd3,
        ST_BURST_ACT  = 3'd4
    } state_e;

    logic [CntWidth-1:0]   div_cnt_q;
    logic                  clk_cyc_q;
    logic                  sync1_q, sync2_q;
    logic                  deb_q, deb_d;
    logic                  deb_dly_q;
    logic [DebWidth-1:0]   deb_cnt_q, deb_cnt_d;
    logic                  halted_q;
    state_e                state_q, state_d;
    logic [BurstWidth-1:0] rem_q, rem_d;
    logic                  clk_en_q, clk_en_d;
    logic                  busy_q, busy_d;

    logic tick_s, step_req_s, gate_s;

    // Tick marks the divider wrap that raises the heartbeat: one per period.
    assign tick_s     = (div_cnt_q == DivLast) & ~clk_cyc_q;
    assign step_req_s = deb_q & ~deb_dly_q;
    assign gate_s     = ~halted_q;

    // Free-running divider and heartbeat; never reset by a mode change.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q <= '0;
            clk_cyc_q <= 1'b0;
        end else if (div_cnt_q == DivLast) begin
            div_cnt_q <= '0;
            clk_cyc_q <= ~clk_cyc_q;
        end else begin
            div_cnt_q <= div_cnt_q + CntWidth'(1);
        end
    end

    // Debounce: accept the synchronised level after DebounceCycles of mismatch.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DebLast) begin
                deb_d     = sync2_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + DebWidth'(1);
            end
        end else begin
            deb_cnt_d = '0;
        end
    end

    // Button synchroniser, debounce state and halt capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
            deb_cnt_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            sync1_q   <= bus.step_btn;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            deb_cnt_q <= deb_cnt_d;
            halted_q  <= bus.halt;
        end
    end

    // Mode FSM next state and enable decision; mode is re-evaluated every
    // cycle so leaving BURST aborts the burst immediately.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        clk_en_d = 1'b0;
        case (bus.mode)
            ModeStop: begin
                state_d = ST_IDLE;
                rem_d   = '0;
            end
            ModeRun: begin
                state_d  = ST_RUN;
                rem_d    = '0;
                clk_en_d = tick_s & gate_s;
            end
            ModeStep: begin
                state_d  = ST_STEP;
                rem_d    = '0;
                clk_en_d = step_req_s & gate_s;
            end
            ModeBurst: begin
                if (state_q == ST_BURST_ACT) begin
                    // Further step requests are ignored while a burst runs.
                    if (tick_s && gate_s) begin
                        clk_en_d = 1'b1;
                        rem_d    = rem_q - BurstWidth'(1);
                        state_d  = (rem_q == BurstWidth'(1)) ? ST_BURST_WAIT : ST_BURST_ACT;
                    end else begin
                        state_d = ST_BURST_ACT;
                    end
                end else begin
                    // A load consumes the coincident tick: no pulse this cycle.
                    if (step_req_s && gate_s && (bus.burst_len != '0)) begin
                        rem_d   = bus.burst_len;
                        state_d = ST_BURST_ACT;
                    end else begin
                        state_d = ST_BURST_WAIT;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                rem_d   = '0;
            end
        endcase
        busy_d = (state_d == ST_BURST_ACT);
    end

    // FSM state, burst counter and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            clk_en_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            clk_en_q <= clk_en_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.clk_en  = clk_en_q;
    assign bus.clk_cyc = clk_cyc_q;
    assign bus.busy    = busy_q;
    assign bus.halted  = halted_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_clock_ctrl
// Scoreboard bench for cpu_clock_ctrl with Div=4, DebounceCycles=3.
// The driver applies inputs on the falling edge, advances a behavioural model
// by one rising edge and queues the expected outputs; the monitor pops one
// entry after every rising edge and compares.
// -----------------------------------------------------------------------------
module tb_cpu_clock_ctrl;

    localparam int DIV = 4;
    localparam int DEB = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    cpu_clock_ctrl_if #(.BurstWidth(8)) bus();

    cpu_clock_ctrl #(
        .ClkFreqHz(8), .RunFreqHz(1), .CntWidth(24),
        .DebounceCycles(DEB), .DebWidth(16), .BurstWidth(8)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic en;
        logic cyc;
        logic busy;
        logic halted;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   en_seen  = 0;

    // ---------------- behavioural model ----------------
    int   m_n;           // rising edges since reset release
    bit   btn_hist[$];   // btn_hist[k-1] = button sampled at edge k
    bit   m_deb, m_deb_prev, m_halted, m_busy;
    int   m_rem;

    // current stimulus values
    logic [1:0] cm;
    logic       cb;
    logic [7:0] cl;
    logic       ch;

    function automatic void chk(string name, logic act, logic expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
        end
    endfunction

    function automatic void chk_int(string name, int act, int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endfunction

    function automatic void reset_model();
        m_n = 0;
        btn_hist.delete();
        m_deb = 1'b0; m_deb_prev = 1'b0; m_halted = 1'b0; m_busy = 1'b0;
        m_rem = 0;
    endfunction

    function automatic bit btn_at(int k);
        if (k >= 1 && k <= btn_hist.size()) return btn_hist[k-1];
        return 1'b0;
    endfunction

    // Advance the model across one rising edge with the given inputs.
    function automatic exp_t model_step(logic [1:0] m, logic b, logic [7:0] l, logic h);
        exp_t e;
        bit tick, sreq, gate, all_v, v, en;
        m_n++;
        btn_hist.push_back(b);
        // heartbeat rises at every odd multiple of DIV; that edge carries the tick
        tick = ((m_n % (2*DIV)) == DIV);
        sreq = m_deb && !m_deb_prev;
        gate = !m_halted;
        // the debounced level flips once the two-flop-delayed button has shown
        // the opposite value for DEB consecutive cycles
        v = !m_deb;
        all_v = 1'b1;
        for (int k = m_n - DEB - 1; k <= m_n - 2; k++)
            if (btn_at(k) != v) all_v = 1'b0;
        m_deb_prev = m_deb;
        if (all_v) m_deb = v;
        en = 1'b0;
        case (m)
            2'b01: begin m_busy = 1'b0; m_rem = 0; en = tick && gate; end
            2'b10: begin m_busy = 1'b0; m_rem = 0; en = sreq && gate; end
            2'b11: begin
                if (!m_busy) begin
                    if (sreq && gate && l != 8'd0) begin
                        m_rem = l; m_busy = 1'b1;
                    end
                end else if (tick && gate) begin
                    en = 1'b1;
                    m_rem = m_rem - 1;
                    if (m_rem == 0) m_busy = 1'b0;
                end
            end
            default: begin m_busy = 1'b0; m_rem = 0; end
        endcase
        m_halted = h;
        e.en = en;
        e.cyc = ((m_n / DIV) % 2) == 1;
        e.busy = m_busy;
        e.halted = m_halted;
        return e;
    endfunction

    // Called on a falling edge: apply inputs, queue expectation, move to next falling edge.
    task automatic drive(input logic [1:0] m, input logic b, input logic [7:0] l, input logic h);
        bus.mode = m; bus.step_btn = b; bus.burst_len = l; bus.halt = h;
        exp_q.push_back(model_step(m, b, l, h));
        @(negedge clk);
    endtask

    task automatic run(input int k);
        repeat (k) drive(cm, cb, cl, ch);
    endtask

    task automatic press(input int hold, input int gap);
        cb = 1'b1; run(hold);
        cb = 1'b0; run(gap);
    endtask

    // Monitor: compare DUT outputs against the queued expectation after each edge.
    exp_t mon_e;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("clk_en",  bus.clk_en,  mon_e.en);
            chk("clk_cyc", bus.clk_cyc, mon_e.cyc);
            chk("busy",    bus.busy,    mon_e.busy);
            chk("halted",  bus.halted,  mon_e.halted);
            if (bus.clk_en === 1'b1) en_seen++;
        end
    end

    initial begin
        int base;
        int mode_hold, btn_hold;
        cm = 2'b01; cb = 1'b0; cl = 8'd0; ch = 1'b0;
        bus.mode = cm; bus.step_btn = cb; bus.burst_len = cl; bus.halt = ch;
        #1 rst_n = 1'b0;
        #22;
        chk("rst_clk_en",  bus.clk_en,  1'b0);
        chk("rst_clk_cyc", bus.clk_cyc, 1'b0);
        chk("rst_busy",    bus.busy,    1'b0);
        chk("rst_halted",  bus.halted,  1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();

        // RUN cadence: pulse every 8 cycles, first on edge 4
        run(40);

        // STEP: one long press gives exactly one pulse
        cm = 2'b10; run(4);
        base = en_seen;
        press(10, 20);
        chk_int("step_single_pulse", en_seen - base, 1);

        // STEP: bouncing press, pulse only once stable
        base = en_seen;
        press(2, 2); press(2, 2); press(10, 20);
        chk_int("step_bounce_pulse", en_seen - base, 1);

        // BURST len 3, second press while busy ignored
        cm = 2'b11; cl = 8'd3; run(3);
        base = en_seen;
        press(6, 12);
        press(6, 50);
        chk_int("burst3_pulses", en_seen - base, 3);

        // BURST len 5 with a halt after pulse 2
        cl = 8'd5;
        base = en_seen;
        press(6, 0);
        for (int i = 0; i < 100 && (en_seen - base) < 2; i++) run(1);
        ch = 1'b1; run(20);
        ch = 1'b0; run(60);
        chk_int("burst5_halt_pulses", en_seen - base, 5);

        // BURST len 4 aborted by STOP after pulse 1
        cl = 8'd4;
        base = en_seen;
        press(6, 0);
        for (int i = 0; i < 100 && (en_seen - base) < 1; i++) run(1);
        cm = 2'b00; run(40);
        chk_int("burst_stop_pulses", en_seen - base, 1);

        // BURST len 0 press does nothing
        cm = 2'b11; cl = 8'd0;
        base = en_seen;
        press(6, 30);
        chk_int("burst_len0_pulses", en_seen - base, 0);

        // Reset mid-burst, then RUN cadence restarts
        cl = 8'd6;
        press(6, 12);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_clk_en",  bus.clk_en,  1'b0);
        chk("arst_clk_cyc", bus.clk_cyc, 1'b0);
        chk("arst_busy",    bus.busy,    1'b0);
        chk("arst_halted",  bus.halted,  1'b0);
        cm = 2'b01; cb = 1'b0; ch = 1'b0;
        bus.mode = cm; bus.step_btn = cb; bus.halt = ch;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        run(30);

        // Randomised traffic
        mode_hold = 0; btn_hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (mode_hold == 0) begin
                cm = 2'($urandom_range(0, 3));
                mode_hold = $urandom_range(10, 120);
            end
            mode_hold--;
            if (btn_hold == 0) begin
                cb = ~cb;
                btn_hold = $urandom_range(1, 8);
            end
            btn_hold--;
            if ($urandom_range(0, 19) == 0) ch = ~ch;
            cl = 8'($urandom_range(0, 5));
            run(1);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
